// File: rtl/nx1_stream_mux.sv
// N-input registered stream multiplexer with explicit-select or round-robin
// arbitration. Define NX1_MUX_XFER_CNT_EN to add the xfer_cnt/cnt_clr transfer counter.
module nx1_stream_mux #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned N     = 4,
   localparam int unsigned SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   input  logic               rr_mode,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_src,
   output logic               out_valid,
   input  logic               out_ready
`ifdef NX1_MUX_XFER_CNT_EN
   ,
   input  logic               cnt_clr,
   output logic [31:0]        xfer_cnt
`endif
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_src_q, out_src_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             load_en;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [SEL_W:0]   rr_sum;
   logic             xfer;

   assign load_en = !out_valid_q || out_ready;

   // Grant selection: explicit select, or first valid channel from rr_ptr upward.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_sum    = '0;
      if (!rr_mode) begin
         if (32'(sel) < N) begin
            grant_vld = 1'b1;
            grant_idx = sel;
         end
      end else begin
         for (int unsigned k = 0; k < N; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            if (rr_sum >= (SEL_W+1)'(N)) begin
               rr_sum = rr_sum - (SEL_W+1)'(N);
            end
            if (!grant_vld && in_valid[rr_sum[SEL_W-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = rr_sum[SEL_W-1:0];
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && load_en && grant_vld) begin
         in_ready[grant_idx] = 1'b1;
      end
   end

   assign xfer = rst_n && load_en && grant_vld && in_valid[grant_idx];

   // Output stage and round-robin pointer next state.
   always_comb begin
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_data_d  = in_data[32'(grant_idx)*WIDTH +: WIDTH];
         out_src_d   = grant_idx;
         out_valid_d = 1'b1;
         if (rr_mode) begin
            rr_ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + SEL_W'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

`ifdef NX1_MUX_XFER_CNT_EN
   logic [31:0] xfer_cnt_q;

   // Clear wins over increment; increment wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt_q <= '0;
      end else if (cnt_clr) begin
         xfer_cnt_q <= '0;
      end else if (xfer) begin
         xfer_cnt_q <= xfer_cnt_q + 32'd1;
      end
   end

   assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_nx1_stream_mux.sv
// Directed self-checking bench for nx1_stream_mux (N=4 and N=3 instances).
module tb_nx1_stream_mux;

   logic        clk;
   logic        rst_n;

   logic [31:0] d4;
   logic [3:0]  v4;
   logic [3:0]  rdy4;
   logic [1:0]  sel4;
   logic        rr4;
   logic [7:0]  od4;
   logic [1:0]  os4;
   logic        ov4;
   logic        ordy4;

   logic [23:0] d3;
   logic [2:0]  v3;
   logic [2:0]  rdy3;
   logic [1:0]  sel3;
   logic        rr3;
   logic [7:0]  od3;
   logic [1:0]  os3;
   logic        ov3;
   logic        ordy3;

   int checks = 0;
   int errors = 0;

`ifdef NX1_MUX_XFER_CNT_EN
   logic        clr4, clr3;
   logic [31:0] cnt4, cnt3;
`endif

   nx1_stream_mux #(.WIDTH(8), .N(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(rdy4),
      .sel(sel4), .rr_mode(rr4), .out_data(od4), .out_src(os4),
      .out_valid(ov4), .out_ready(ordy4)
`ifdef NX1_MUX_XFER_CNT_EN
      , .cnt_clr(clr4), .xfer_cnt(cnt4)
`endif
   );

   nx1_stream_mux #(.WIDTH(8), .N(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(rdy3),
      .sel(sel3), .rr_mode(rr3), .out_data(od3), .out_src(os3),
      .out_valid(ov3), .out_ready(ordy3)
`ifdef NX1_MUX_XFER_CNT_EN
      , .cnt_clr(clr3), .xfer_cnt(cnt3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      d4 = {8'h44, 8'h5A, 8'h22, 8'h11};
      v4 = 4'b1111; sel4 = 2'd0; rr4 = 1'b1; ordy4 = 1'b1;
      d3 = {8'h33, 8'h22, 8'h11};
      v3 = 3'b000; sel3 = 2'd0; rr3 = 1'b0; ordy3 = 1'b1;
`ifdef NX1_MUX_XFER_CNT_EN
      clr4 = 1'b0; clr3 = 1'b0;
`endif
      tick(); tick();

      // Reset state
      chk("rst_valid", 32'(ov4), 32'h0);
      chk("rst_data", 32'(od4), 32'h0);
      chk("rst_src", 32'(os4), 32'h0);
      chk("rst_ready", 32'(rdy4), 32'h0);

      // Explicit select of channel 2
      rst_n = 1'b1; rr4 = 1'b0; sel4 = 2'd2;
      #1;
      chk("exp_ready", 32'(rdy4), 32'h4);
      tick();
      chk("exp_data", 32'(od4), 32'h5A);
      chk("exp_src", 32'(os4), 32'h2);
      chk("exp_valid", 32'(ov4), 32'h1);
      v4 = 4'b0000;
      tick();
      chk("exp_drain_valid", 32'(ov4), 32'h0);
      chk("exp_drain_hold", 32'(od4), 32'h5A);

      // Round-robin, all valid: 0,1,2,3,0,1,2,3 with no bubbles
      rr4 = 1'b1; v4 = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("rr_ready", 32'(rdy4), 32'(1 << (i % 4)));
         tick();
         chk("rr_src", 32'(os4), 32'(i % 4));
         chk("rr_valid", 32'(ov4), 32'h1);
         chk("rr_data", 32'(od4), 32'(d4[(i % 4)*8 +: 8]));
      end

      // Only channels 1 and 3 valid: alternates 1,3,1,3
      v4 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr13_src", 32'(os4), (i % 2 == 0) ? 32'd1 : 32'd3);
      end

      // Backpressure: hold 0x44 from channel 3 while inputs change
      ordy4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v4 = 4'(1 << i);
         d4 = {8'hAA, 8'hBB, 8'hCC, 8'(8'hD0 + i)};
         sel4 = 2'(i);
         #1;
         chk("bp_ready", 32'(rdy4), 32'h0);
         tick();
         chk("bp_data", 32'(od4), 32'h44);
         chk("bp_src", 32'(os4), 32'h3);
         chk("bp_valid", 32'(ov4), 32'h1);
      end
      d4 = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
      v4 = 4'b1111;
      ordy4 = 1'b1;
      #1;
      chk("bp_release_ready", 32'(rdy4), 32'h1);
      tick();
      chk("bp_refill_data", 32'(od4), 32'hDD);
      chk("bp_refill_src", 32'(os4), 32'h0);
      chk("bp_refill_valid", 32'(ov4), 32'h1);

      // Mid-stream reset with a held word; rr_ptr was 1
      ordy4 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(ov4), 32'h0);
      chk("mrst_data", 32'(od4), 32'h0);
      chk("mrst_src", 32'(os4), 32'h0);
      chk("mrst_ready", 32'(rdy4), 32'h0);
      tick();
      rst_n = 1'b1; ordy4 = 1'b1;
      #1;
      chk("mrst_rr_ready", 32'(rdy4), 32'h1);
      tick();
      chk("mrst_rr_src", 32'(os4), 32'h0);
      chk("mrst_rr_data", 32'(od4), 32'hDD);
      v4 = 4'b0000;
      tick();

      // N=3: out-of-range select yields no grant and the held word drains
      v3 = 3'b111; sel3 = 2'd2;
      #1;
      chk("n3_ready_sel2", 32'(rdy3), 32'h4);
      tick();
      chk("n3_data", 32'(od3), 32'h33);
      chk("n3_valid", 32'(ov3), 32'h1);
      sel3 = 2'd3;
      #1;
      chk("n3_oor_ready", 32'(rdy3), 32'h0);
      tick();
      chk("n3_oor_valid", 32'(ov3), 32'h0);
      chk("n3_oor_hold", 32'(od3), 32'h33);
      v3 = 3'b000;

`ifdef NX1_MUX_XFER_CNT_EN
      clr4 = 1'b1;
      tick();
      clr4 = 1'b0;
      chk("cnt_clr_idle", cnt4, 32'd0);
      v4 = 4'b1111;
      for (int i = 0; i < 5; i++) tick();
      v4 = 4'b0000;
      tick();
      chk("cnt_five", cnt4, 32'd5);
      v4 = 4'b1111; clr4 = 1'b1;
      tick();
      chk("cnt_clr_xfer", cnt4, 32'd0);
      chk("cnt_clr_xfer_valid", 32'(ov4), 32'h1);
      v4 = 4'b0000; clr4 = 1'b0;
      tick();
      chk("cnt_after_clr", cnt4, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nx1_stream_mux.md
Name: nx1_stream_mux

Overview:
- Parametrised N-input, WIDTH-bit registered stream multiplexer for the GCD datapath and the blocks that follow it.
- Replaces the combinational 2:1 select where operands arrive from several producers with valid/ready flow control.
- Selects one input per cycle, either by an explicit select or by a round-robin arbiter, and registers it into a single-entry output stage.
- The selected source index travels with the data.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2).
- SEL_W, $clog2(N), select/index width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; combinational from state and inputs.
- sel  input  SEL_W  explicit channel select; used when rr_mode=0.
- rr_mode  input  1  0 = explicit select, 1 = round-robin arbitration.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset, asynchronous on rst_n low: out_valid=0, out_data=0, out_src=0, rr_ptr=0. in_ready is 0 while in reset.
- load_en = !out_valid || out_ready. The output stage accepts a new word in any cycle where it is empty or being drained.
- Explicit mode (rr_mode=0):
  - grant = sel.
  - If sel >= N (non-power-of-2 N), there is no grant and in_ready is all 0.
- Round-robin mode (rr_mode=1):
  - grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N.
  - No valid channel means no grant.
- in_ready[i] = load_en && grant_exists && (i == grant). At most one in_ready bit is high.
- Transfer on channel g: in_valid[g] && in_ready[g]. On the next edge: out_data <= channel g data, out_src <= g, out_valid <= 1.
- In round-robin mode only, rr_ptr <= (g+1) mod N on each transfer. rr_ptr is unchanged in explicit mode and on cycles with no transfer.
- Drain without refill (out_valid && out_ready, no transfer): out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid && !out_ready):
  - out_data and out_src stay stable.
  - in_ready is all 0.
  - No input is consumed, including one that becomes valid during the stall.
- Simultaneous drain and refill: new word loaded, out_valid stays 1. Sustains 1 word/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Changing rr_mode or sel affects only the next arbitration. The word already in the output register is never altered.
- Round-robin fairness: with all N inputs continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... Each channel waits at most N-1 transfers.
- Reset asserted mid-operation: the held word is discarded immediately, rr_ptr returns to 0, and no transfer completes in that cycle.
- in_valid on a non-granted channel has no effect. Producers hold their data until their own in_ready is high.

Optional Feature:
- Macro: NX1_MUX_XFER_CNT_EN.
- When defined, the block adds output xfer_cnt (32 bits), reset to 0.
  - It increments by 1 on every input transfer and wraps from 0xFFFFFFFF to 0.
  - It also adds input cnt_clr (1 bit), a synchronous clear that takes priority over increment in the same cycle.
- When undefined, neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset: apply rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_src=0 immediately; after release, first round-robin grant goes to channel 0.
- Explicit select, N=4, WIDTH=8: sel=2, in_valid=4'b1111, in_data ch2=0x5A, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x5A, out_src=2, out_valid=1.
- Round-robin: all channels valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with no bubbles. Then only ch1 and ch3 valid -> alternates 1,3,1,3.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while inputs change -> out_data/out_src constant, in_ready=0. Raising out_ready -> drain and refill in the same cycle, out_valid stays 1.
- Out-of-range select, N=3: sel=3 with in_valid=3'b111 -> in_ready=0; out_valid drops after the held word drains.
- NX1_MUX_XFER_CNT_EN: 5 transfers -> xfer_cnt=5. cnt_clr together with a transfer -> xfer_cnt=0. Counter preset 0xFFFFFFFF then one transfer -> 0.
